// File: rtl/cg_iteration_sequencer_if.sv
// Handshake bundle between the CG datapath and its iteration sequencer.
// master = datapath/driver side, slave = sequencer side.
interface cg_iteration_sequencer_if #(
    parameter int element_width = 32
);
    logic                     go;
    logic                     rsnew_valid;
    logic [element_width-1:0] rsnew;
    logic                     mul_add3_finish;
    logic                     reset_vXv1;
    logic                     reset_mXv1;
    logic                     busy;
    logic                     finish_all;
    logic                     converged;
    logic                     limit_hit;
    logic                     nan_err;
    logic [31:0]              iteration_count;
    logic [element_width-1:0] rsnew_last;

    modport master (
        output go, rsnew_valid, rsnew, mul_add3_finish,
        input  reset_vXv1, reset_mXv1, busy, finish_all,
        input  converged, limit_hit, nan_err,
        input  iteration_count, rsnew_last
    );

    modport slave (
        input  go, rsnew_valid, rsnew, mul_add3_finish,
        output reset_vXv1, reset_mXv1, busy, finish_all,
        output converged, limit_hit, nan_err,
        output iteration_count, rsnew_last
    );
endinterface

// File: rtl/cg_iteration_sequencer.sv
// Conjugate-gradient iteration controller: releases datapath resets, checks r.r.
// Optional iteration limit compiled in with CG_ITER_LIMIT_EN.
module cg_iteration_sequencer #(
    parameter int          element_width  = 32,
    parameter logic [31:0] tolerance      = 32'h283424DC,
    parameter int          max_iterations = 1000,
    parameter int          restart_gap    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cg_iteration_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     rst_dp_q, rst_dp_d;
    logic                     busy_q, busy_d;
    logic                     finish_q, finish_d;
    logic                     conv_q, conv_d;
    logic                     limit_q, limit_d;
    logic                     nan_q, nan_d;
    logic                     got_r_q, got_r_d;
    logic                     got_p_q, got_p_d;
    logic [31:0]              iter_q, iter_d;
    logic [15:0]              gap_q, gap_d;
    logic [element_width-1:0] last_q, last_d;

    logic [31:0] count_inc;
    logic [30:0] mag;
    logic        non_finite;
    logic        within_tol;
    logic        lim_reached;
    logic        r_done;
    logic        p_done;

    assign count_inc  = iter_q + 32'd1;
    assign mag        = last_q[30:0];
    assign non_finite = (last_q[30:23] == 8'hFF);
    assign within_tol = (mag <= tolerance[30:0]);
    assign r_done     = got_r_q | bus.rsnew_valid;
    assign p_done     = got_p_q | bus.mul_add3_finish;

`ifdef CG_ITER_LIMIT_EN
    assign lim_reached = (count_inc == 32'(max_iterations));
`else
    localparam int unused_max_iterations = max_iterations;
    assign lim_reached = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rst_dp_d = rst_dp_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        conv_d   = conv_q;
        limit_d  = limit_q;
        nan_d    = nan_q;
        got_r_d  = got_r_q;
        got_p_d  = got_p_q;
        iter_d   = iter_q;
        gap_d    = gap_q;
        last_d   = last_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    state_d  = S_RUN;
                    rst_dp_d = 1'b0;
                    busy_d   = 1'b1;
                    finish_d = 1'b0;
                    conv_d   = 1'b0;
                    limit_d  = 1'b0;
                    nan_d    = 1'b0;
                    got_r_d  = 1'b0;
                    got_p_d  = 1'b0;
                    iter_d   = '0;
                end
            end
            S_RUN: begin
                // only the first residual of an iteration is kept
                if (bus.rsnew_valid && !got_r_q) begin
                    last_d  = bus.rsnew;
                    got_r_d = 1'b1;
                end
                if (bus.mul_add3_finish) begin
                    got_p_d = 1'b1;
                end
                if (r_done && p_done) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                iter_d = count_inc;
                if (non_finite || within_tol || lim_reached) begin
                    state_d  = S_DONE;
                    rst_dp_d = 1'b1;
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                    if (non_finite) begin
                        nan_d = 1'b1;
                    end else if (within_tol) begin
                        conv_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    state_d  = S_GAP;
                    rst_dp_d = 1'b1;
                    gap_d    = 16'(restart_gap - 1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d  = S_RUN;
                    rst_dp_d = 1'b0;
                    got_r_d  = 1'b0;
                    got_p_d  = 1'b0;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rst_dp_q <= 1'b1;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            conv_q   <= 1'b0;
            limit_q  <= 1'b0;
            nan_q    <= 1'b0;
            got_r_q  <= 1'b0;
            got_p_q  <= 1'b0;
            iter_q   <= '0;
            gap_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            rst_dp_q <= rst_dp_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            conv_q   <= conv_d;
            limit_q  <= limit_d;
            nan_q    <= nan_d;
            got_r_q  <= got_r_d;
            got_p_q  <= got_p_d;
            iter_q   <= iter_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
        end
    end

    assign bus.reset_vXv1      = rst_dp_q;
    assign bus.reset_mXv1      = rst_dp_q;
    assign bus.busy            = busy_q;
    assign bus.finish_all      = finish_q;
    assign bus.converged       = conv_q;
    assign bus.limit_hit       = limit_q;
    assign bus.nan_err         = nan_q;
    assign bus.iteration_count = iter_q;
    assign bus.rsnew_last      = last_q;

endmodule

// File: doc/cg_iteration_sequencer.md
# cg_iteration_sequencer

Iteration controller for the conjugate-gradient solver datapath. It starts a solve, releases the datapath stage resets at the start of each iteration, and captures the new residual norm (r·r, the vXv3 result) once per iteration. At the end of each iteration it tests that value against a tolerance and either re-arms the datapath for the next iteration or raises `finish_all`. It sits directly downstream of the residual dot-product and p-update stages, and upstream of their reset inputs.

## Interface
- `element_width`, 32, width of the residual value (IEEE-754 single).
- `tolerance`, 32'h283424DC, convergence threshold as a positive float bit pattern.
- `max_iterations`, 1000, iteration limit; only used when `CG_ITER_LIMIT_EN` is defined.
- `restart_gap`, 2, cycles the datapath resets stay high between iterations (≥1).

- `clk` input 1 — clock.
- `reset` input 1 — synchronous, active-high.
- `go` input 1 — start pulse; sampled only in IDLE or DONE.
- `rsnew_valid` input 1 — single-cycle pulse when `rsnew` is valid (the vXv3 finish).
- `rsnew` input element_width — new residual norm.
- `mul_add3_finish` input 1 — pulse marking completion of the p update.
- `reset_vXv1` output 1 — active-high hold for the r·r dot-product stage.
- `reset_mXv1` output 1 — active-high hold for the A·p stage.
- `busy` output 1 — a solve is in progress.
- `finish_all` output 1 — solve ended; held high until the next `go` or `reset`.
- `converged` output 1 — the solve ended because the residual was within tolerance.
- `limit_hit` output 1 — the solve ended on the iteration limit.
- `nan_err` output 1 — the solve ended because `rsnew` was NaN or Inf.
- `iteration_count` output 32 — number of completed iterations.
- `rsnew_last` output element_width — last captured residual.

## Operation
- States: IDLE, RUN, CHECK, GAP, DONE.
- Reset values:
  - State is IDLE.
  - `reset_vXv1` = `reset_mXv1` = 1.
  - `busy`, `finish_all`, `converged`, `limit_hit`, `nan_err` = 0.
  - `iteration_count` = 0 and `rsnew_last` = 0.
- IDLE, on `go`:
  - Go to RUN.
  - Drive both resets to 0 and `busy` to 1.
- RUN:
  - Two sticky flags, `got_r` and `got_p`, are cleared on entry to RUN.
  - On the first `rsnew_valid` of the iteration, capture `rsnew` into `rsnew_last` and set `got_r`. Later `rsnew_valid` pulses in the same iteration are ignored.
  - `mul_add3_finish` sets `got_p`.
  - The two events may arrive in either order or in the same cycle.
  - When both flags are set (including the cycle they become set), go to CHECK on the next edge.
- CHECK (exactly 1 cycle):
  - Increment `iteration_count` (wraps at 2^32).
  - Let mag = `rsnew_last[30:0]` and exp = `rsnew_last[30:23]`.
  - If exp == 8'hFF: set `nan_err`, go to DONE.
  - Else if mag ≤ `tolerance[30:0]` (unsigned compare; the sign bit is ignored, so -0 converges): set `converged`, go to DONE.
  - Else, when the limit is compiled in and the incremented count equals `max_iterations`: set `limit_hit`, go to DONE.
  - Otherwise: go to GAP and drive both resets to 1.
  - Priority is nan_err > converged > limit_hit.
- GAP:
  - Hold both resets at 1 for `restart_gap` cycles.
  - Then go to RUN with both resets at 0.
- DONE:
  - `finish_all` = 1, `busy` = 0, both resets held at 1.
  - Outcome flags, `iteration_count` and `rsnew_last` are held.
  - On `go`: clear `finish_all` and all flags, clear `iteration_count`, go to RUN as from IDLE.
- `go` is ignored in RUN, CHECK and GAP.
- `rsnew_valid` and `mul_add3_finish` are ignored outside RUN.
- `reset` has priority over every other input in every state. All outputs take their reset values at the next edge, including in the middle of a solve.

## Timing
- `go` sampled at edge k:
  - `busy` = 1 and both resets = 0 from edge k.
  - The datapath sees its resets released from cycle k+1.
- Last of the two finish events sampled at edge m:
  - CHECK is the state during cycle m+1.
  - `iteration_count` updates at edge m+1.
- Outcome at edge m+1:
  - A DONE outcome shows `finish_all` and the outcome flag from edge m+1.
  - Otherwise both resets rise at edge m+1 and fall at edge m+1+`restart_gap`.
- End-of-iteration to next-iteration release latency is 1 + `restart_gap` cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CG_ITER_LIMIT_EN`:
  - Defined: the `max_iterations` check is compiled in and `limit_hit` can assert.
  - Undefined: the check logic is omitted, `limit_hit` is tied to 0, and the solve ends only on convergence or `nan_err`.

## Test plan
- **Single-iteration convergence.** Reset, then `go`. `rsnew_valid` with `rsnew`=32'h20000000, then `mul_add3_finish` 3 cycles later → one CHECK cycle, `converged`=1, `finish_all`=1, `iteration_count`=1, both resets high.
- **Three iterations, out-of-order events.**
  - Iterations 1 and 2: `rsnew`=32'h3F800000 (1.0), with `mul_add3_finish` arriving first → resets high for exactly 2 cycles after each CHECK.
  - Iteration 3: `rsnew`=32'h283424DC → `converged`, `iteration_count`=3.
- **Simultaneous events and NaN.** `rsnew_valid` and `mul_add3_finish` in the same cycle with `rsnew`=32'h7FC00000 → `nan_err`=1, `converged`=0, DONE at the following edge.
- **Iteration limit.** Build with `CG_ITER_LIMIT_EN` and `max_iterations`=4; `rsnew` is always 1.0 → `limit_hit` after the 4th CHECK, `iteration_count`=4. The same bench built without the macro keeps iterating past 4.
- **Reset mid-GAP and ignored `go`.** Pulse `go` during RUN → no effect. Assert `reset` during GAP → next edge shows IDLE, `iteration_count`=0, both resets=1. A fresh `go` then restarts normally.
- **Restart from DONE.** After convergence, pulse `go` → `finish_all` and `converged` clear at the same edge, `iteration_count`=0, and both resets are low from the following cycle.
